// File: rtl/tnn_pkg.sv
// -----------------------------------------------------------------------------
// tnn_pkg
// Shared definitions for the ternary-neuron sequencer:
//   - default array/accumulator dimensions
//   - serial weight encoding (two bits per synapse: zero flag, sign)
//   - sequencer state encoding
// -----------------------------------------------------------------------------
package tnn_pkg;

  // Default geometry: 32-synapse array, 4 tiles -> 128-input neuron.
  localparam int TNN_N     = 32;
  localparam int TNN_SUM_W = 7;
  localparam int TNN_TILES = 4;
  localparam int TNN_ACC_W = 9;

  // Weight register layout: synapse i occupies bits {2i+1, 2i}.
  // Zero flag set -> weight 0; otherwise sign 0 -> +1, sign 1 -> -1.
  localparam int WT_BITS_PER_SYN = 2;
  localparam int WT_ZERO_OFS     = 0;
  localparam int WT_SIGN_OFS     = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    APPLY   = 3'd2,
    CAPTURE = 3'd3,
    OUTPUT  = 3'd4
  } state_e;

endpackage

// File: rtl/tnn_neuron_sequencer_if.sv
// -----------------------------------------------------------------------------
// tnn_neuron_sequencer_if
// Bundles every non-clock/reset signal of the sequencer: control (start, abort,
// threshold), weight-bit stream, input-vector stream, synapse-array drive and
// sense, result handshake and busy.
//   master : the host side (drives start/streams/sum_in/out_ready)
//   slave  : the sequencer itself
// Optional: ACC_SATURATE_EN adds the out_sat result flag.
// -----------------------------------------------------------------------------
interface tnn_neuron_sequencer_if #(
  parameter int N     = 32,
  parameter int SUM_W = 7,
  parameter int ACC_W = 9
);

  logic                    start;
  logic                    abort;
  logic signed [ACC_W-1:0] threshold;
  logic                    wt_valid;
  logic                    wt_bit;
  logic                    wt_ready;
  logic                    x_valid;
  logic [N-1:0]            x_data;
  logic                    x_ready;
  logic                    w_shift;
  logic                    w_bit;
  logic [N-1:0]            x_out;
  logic signed [SUM_W-1:0] sum_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc;
  logic                    out_act;
  logic                    busy;
`ifdef ACC_SATURATE_EN
  logic                    out_sat;
`endif

  modport master (
    output start, abort, threshold, wt_valid, wt_bit, x_valid, x_data, sum_in, out_ready,
    input  wt_ready, x_ready, w_shift, w_bit, x_out, out_valid, out_acc, out_act, busy
`ifdef ACC_SATURATE_EN
    , input out_sat
`endif
  );

  modport slave (
    input  start, abort, threshold, wt_valid, wt_bit, x_valid, x_data, sum_in, out_ready,
    output wt_ready, x_ready, w_shift, w_bit, x_out, out_valid, out_acc, out_act, busy
`ifdef ACC_SATURATE_EN
    , output out_sat
`endif
  );

endinterface

// File: rtl/tnn_accumulator.sv
// -----------------------------------------------------------------------------
// tnn_accumulator
// Signed tile accumulator. clear_i zeroes the sum (and the clamp flag); add_i
// adds the sign-extended array sum. clear_i wins over add_i.
// Optional: ACC_SATURATE_EN clamps the add to the ACC_W signed range and keeps
// a sticky sat_o flag; otherwise the add wraps modulo 2^ACC_W.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clear_i   zero accumulator (and sat flag)
//   add_i     acc += sext(sum_i)
//   sum_i     signed array sum, SUM_W bits
//   acc_o     signed accumulator, ACC_W bits
//   sat_o     sticky clamp flag (ACC_SATURATE_EN only)
// -----------------------------------------------------------------------------
module tnn_accumulator
  import tnn_pkg::*;
#(
  parameter int SUM_W = TNN_SUM_W,
  parameter int ACC_W = TNN_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    add_i,
  input  logic signed [SUM_W-1:0] sum_i,
  output logic signed [ACC_W-1:0] acc_o
`ifdef ACC_SATURATE_EN
  , output logic                  sat_o
`endif
);

  logic signed [ACC_W-1:0] acc_q, acc_d;

`ifdef ACC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                  sat_q, sat_d;
  logic signed [ACC_W:0] sum_wide;
  logic                  ovf;

  // One guard bit: overflow shows up as the two top bits disagreeing.
  assign sum_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(sum_i);
  assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

  // NOTE: every variable gets its default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (clear_i) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (add_i) begin
      if (ovf) begin
        acc_d = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        sat_d = 1'b1;
      end else begin
        acc_d = sum_wide[ACC_W-1:0];
      end
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign sat_o = sat_q;
`else
  // NOTE: every variable gets its default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + ACC_W'(sum_i);
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
`endif

  assign acc_o = acc_q;

endmodule

// File: rtl/tnn_neuron_sequencer.sv
// -----------------------------------------------------------------------------
// tnn_neuron_sequencer
// Time-multiplexes one N-input ternary synapse array over TILES tiles to build
// a neuron with N*TILES fan-in. Per tile: stream 2N weight bits into the array,
// latch one input vector, then add the array sum into the accumulator. After the
// last tile the accumulated pre-activation and (acc > threshold) are offered
// on the result handshake until accepted.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        tnn_neuron_sequencer_if.slave:
//                start/abort/threshold control, wt_* weight stream,
//                x_* input-vector stream, w_shift/w_bit/x_out/sum_in array
//                interface, out_* result, busy
// Optional: ACC_SATURATE_EN -> saturating accumulator plus out_sat flag.
// -----------------------------------------------------------------------------
module tnn_neuron_sequencer
  import tnn_pkg::*;
#(
  parameter int N     = TNN_N,
  parameter int SUM_W = TNN_SUM_W,
  parameter int TILES = TNN_TILES,
  parameter int ACC_W = TNN_ACC_W
) (
  input logic                   clk,
  input logic                   rst,
  tnn_neuron_sequencer_if.slave bus
);

  localparam int WT_BITS = WT_BITS_PER_SYN * N;
  localparam int BIT_W   = $clog2(WT_BITS);
  localparam int TILE_W  = (TILES > 1) ? $clog2(TILES) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WT_BITS - 1);
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(TILES - 1);

  state_e                  state_q, state_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [TILE_W-1:0]       tile_cnt_q, tile_cnt_d;
  logic signed [ACC_W-1:0] thr_q, thr_d;
  logic [N-1:0]            x_out_q, x_out_d;

  logic                    acc_clear;
  logic                    acc_add;
  logic signed [ACC_W-1:0] acc;
  logic                    wt_fire;

  assign wt_fire = (state_q == LOAD) && bus.wt_valid;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tile_cnt_d = tile_cnt_q;
    thr_d      = thr_q;
    x_out_d    = x_out_q;
    acc_clear  = 1'b0;
    acc_add    = 1'b0;

    // abort overrides every other event; x_out deliberately keeps its value.
    if (bus.abort) begin
      state_d   = IDLE;
      acc_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_clear  = 1'b1;
            bit_cnt_d  = '0;
            tile_cnt_d = '0;
            thr_d      = bus.threshold;
            state_d    = LOAD;
          end
        end
        LOAD: begin
          if (wt_fire) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) state_d = APPLY;
          end
        end
        APPLY: begin
          if (bus.x_valid) begin
            x_out_d = bus.x_data;
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          // Array sum is settled: weights loaded, x_out registered last cycle.
          acc_add    = 1'b1;
          tile_cnt_d = tile_cnt_q + 1'b1;
          if (tile_cnt_q == TILE_LAST) begin
            state_d = OUTPUT;
          end else begin
            bit_cnt_d = '0;
            state_d   = LOAD;
          end
        end
        OUTPUT: begin
          // A start arriving with the retiring handshake is dropped on purpose.
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tile_cnt_q <= '0;
      thr_q      <= '0;
      x_out_q    <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tile_cnt_q <= tile_cnt_d;
      thr_q      <= thr_d;
      x_out_q    <= x_out_d;
    end
  end

  tnn_accumulator #(
    .SUM_W (SUM_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clear_i (acc_clear),
    .add_i   (acc_add),
    .sum_i   (bus.sum_in),
    .acc_o   (acc)
`ifdef ACC_SATURATE_EN
    , .sat_o (bus.out_sat)
`endif
  );

  assign bus.wt_ready  = (state_q == LOAD);
  assign bus.w_shift   = wt_fire;
  assign bus.w_bit     = (state_q == LOAD) && bus.wt_bit;
  assign bus.x_ready   = (state_q == APPLY);
  assign bus.x_out     = x_out_q;
  assign bus.out_valid = (state_q == OUTPUT);
  assign bus.out_acc   = acc;
  assign bus.out_act   = (state_q == OUTPUT) && (acc > thr_q);
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tnn_neuron_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tnn_neuron_sequencer
// Drives the sequencer in front of a behavioural synapse array. A second
// instance with a 7-bit accumulator runs in lockstep on the same stimulus to
// exercise wrap (default) or clamp (ACC_SATURATE_EN) behaviour.
// Expected results come from the ternary weight values chosen by the bench and
// are queued at start; the monitor pops them when out_valid appears.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tnn_neuron_sequencer;
  import tnn_pkg::*;

  localparam int N      = TNN_N;
  localparam int SUM_W  = TNN_SUM_W;
  localparam int TILES  = TNN_TILES;
  localparam int ACC_W  = TNN_ACC_W;
  localparam int ACC_W7 = 7;

  typedef struct {
    int acc;  bit act;  bit sat;
    int acc7; bit act7; bit sat7;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tnn_neuron_sequencer_if #(.N(N), .SUM_W(SUM_W), .ACC_W(ACC_W))  bus ();
  tnn_neuron_sequencer_if #(.N(N), .SUM_W(SUM_W), .ACC_W(ACC_W7)) bus7 ();

  tnn_neuron_sequencer #(.N(N), .SUM_W(SUM_W), .TILES(TILES), .ACC_W(ACC_W))
    u_dut  (.clk(clk), .rst(rst), .bus(bus));
  tnn_neuron_sequencer #(.N(N), .SUM_W(SUM_W), .TILES(TILES), .ACC_W(ACC_W7))
    u_dut7 (.clk(clk), .rst(rst), .bus(bus7));

  assign bus7.start     = bus.start;
  assign bus7.abort     = bus.abort;
  assign bus7.threshold = bus.threshold[ACC_W7-1:0];
  assign bus7.wt_valid  = bus.wt_valid;
  assign bus7.wt_bit    = bus.wt_bit;
  assign bus7.x_valid   = bus.x_valid;
  assign bus7.x_data    = bus.x_data;
  assign bus7.out_ready = bus.out_ready;

  // ---------------- behavioural synapse arrays ----------------
  logic [2*N-1:0] arr_w  = '0;
  logic [2*N-1:0] arr7_w = '0;

  always @(posedge clk) if (bus.w_shift)  arr_w  <= {arr_w[2*N-2:0], bus.w_bit};
  always @(posedge clk) if (bus7.w_shift) arr7_w <= {arr7_w[2*N-2:0], bus7.w_bit};

  function automatic int array_sum(input logic [2*N-1:0] w, input logic [N-1:0] x);
    int s = 0;
    for (int i = 0; i < N; i++)
      if (x[i] && !w[2*i+WT_ZERO_OFS]) s += w[2*i+WT_SIGN_OFS] ? -1 : 1;
    return s;
  endfunction

  assign bus.sum_in  = SUM_W'(array_sum(arr_w,  bus.x_out));
  assign bus7.sum_in = SUM_W'(array_sum(arr7_w, bus7.x_out));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- stimulus storage ----------------
  bit           wt_q[$];
  logic [N-1:0] x_q[$];
  exp_t         exp_q[$];
  bit           gaps = 1'b0;
  bit           wt_fire_r = 1'b0;
  bit           x_fire_r  = 1'b0;
  bit           mon_seen  = 1'b0;

  int           cur_w [TILES][N];
  logic [N-1:0] cur_x [TILES];

  // Reference accumulate step for a width-w signed accumulator.
  function automatic int acc_step(input int acc, input int s, input int w, output bit clamped);
    int lo = -(1 << (w - 1));
    int hi = (1 << (w - 1)) - 1;
    int v  = acc + s;
    clamped = 1'b0;
`ifdef ACC_SATURATE_EN
    if (v > hi)      begin v = hi; clamped = 1'b1; end
    else if (v < lo) begin v = lo; clamped = 1'b1; end
`else
    if (v > hi)      v -= (hi - lo + 1);
    else if (v < lo) v += (hi - lo + 1);
`endif
    return v;
  endfunction

  task automatic set_uniform(input int w, input logic [N-1:0] x);
    for (int t = 0; t < TILES; t++) begin
      cur_x[t] = x;
      for (int i = 0; i < N; i++) cur_w[t][i] = w;
    end
  endtask

  task automatic set_random();
    for (int t = 0; t < TILES; t++) begin
      cur_x[t] = N'($urandom());
      for (int i = 0; i < N; i++) cur_w[t][i] = int'($urandom_range(2, 0)) - 1;
    end
  endtask

  // Encode weights MSB-first into the stream, queue vectors and expected result.
  task automatic queue_eval(input int thr);
    logic [2*N-1:0]           wreg;
    logic signed [ACC_W7-1:0] thr7;
    exp_t e;
    int   s;
    bit   c;
    e = '{acc: 0, act: 1'b0, sat: 1'b0, acc7: 0, act7: 1'b0, sat7: 1'b0};
    for (int t = 0; t < TILES; t++) begin
      s = 0;
      for (int i = 0; i < N; i++) begin
        wreg[2*i+WT_ZERO_OFS] = (cur_w[t][i] == 0);
        wreg[2*i+WT_SIGN_OFS] = (cur_w[t][i] < 0) ? 1'b1 :
                                (cur_w[t][i] == 0) ? 1'($urandom_range(1, 0)) : 1'b0;
        if (cur_x[t][i]) s += cur_w[t][i];
      end
      for (int b = 2*N-1; b >= 0; b--) wt_q.push_back(wreg[b]);
      x_q.push_back(cur_x[t]);
      e.acc  = acc_step(e.acc,  s, ACC_W,  c); e.sat  |= c;
      e.acc7 = acc_step(e.acc7, s, ACC_W7, c); e.sat7 |= c;
    end
    thr7   = ACC_W7'(thr);
    e.act  = (e.acc  > thr);
    e.act7 = (e.acc7 > int'(thr7));
    exp_q.push_back(e);
    bus.threshold = ACC_W'(thr);
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (bus.busy && n < 5000);
    check("idle_reached", bus.busy, 0);
  endtask

  task automatic flush_streams();
    wt_q.delete();
    x_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stream drivers (data moves at negedge, fire taken at posedge) ----------------
  initial begin
    bus.wt_valid = 1'b0;
    bus.wt_bit   = 1'b0;
    forever begin
      @(negedge clk);
      if (wt_fire_r && wt_q.size() > 0) void'(wt_q.pop_front());
      if (wt_q.size() > 0 && (!gaps || $urandom_range(1, 0) == 1)) begin
        bus.wt_valid = 1'b1;
        bus.wt_bit   = wt_q[0];
      end else begin
        bus.wt_valid = 1'b0;
      end
      wt_fire_r = bus.wt_valid && bus.wt_ready;
    end
  end

  initial begin
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    forever begin
      @(negedge clk);
      if (x_fire_r && x_q.size() > 0) void'(x_q.pop_front());
      if (x_q.size() > 0 && (!gaps || $urandom_range(1, 0) == 1)) begin
        bus.x_valid = 1'b1;
        bus.x_data  = x_q[0];
      end else begin
        bus.x_valid = 1'b0;
      end
      x_fire_r = bus.x_valid && bus.x_ready;
    end
  end

  // ---------------- result monitor / scoreboard ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid && !mon_seen) begin
        mon_seen = 1'b1;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_acc",    int'(bus.out_acc),  e.acc);
          check("out_act",    bus.out_act,        e.act);
          check("out7_valid", bus7.out_valid,     1);
          check("out7_acc",   int'(bus7.out_acc), e.acc7);
          check("out7_act",   bus7.out_act,       e.act7);
`ifdef ACC_SATURATE_EN
          check("out_sat",    bus.out_sat,        e.sat);
          check("out7_sat",   bus7.out_sat,       e.sat7);
`endif
        end
      end
      if (!bus.out_valid || bus.out_ready) mon_seen = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int fires;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.threshold = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy",      bus.busy,      0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_wt_ready",  bus.wt_ready,  0);
    check("rst_x_ready",   bus.x_ready,   0);
    check("rst_x_out",     bus.x_out,     0);
    check("rst_out_acc",   bus.out_acc,   0);

    // Reset in the middle of the second tile's weight load.
    set_uniform(1, '1);
    queue_eval(0);
    pulse_start();
    repeat (80) @(negedge clk);
    check("pre_rst_in_load", bus.wt_ready, 1);
    check("pre_rst_x_out",   bus.x_out,    cur_x[0]);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy",      bus.busy,      0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_wt_ready",  bus.wt_ready,  0);
    check("midrst_x_out",     bus.x_out,     0);
    flush_streams();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // All +1, all-ones input, zero stalls: 128 and latency 1 + TILES*(2N+2).
    set_uniform(1, '1);
    queue_eval(100);
    @(negedge clk); bus.start = 1'b1; n = 0;
    do begin @(negedge clk); bus.start = 1'b0; n++; end while (!bus.out_valid && n < 2000);
    check("latency", n, 1 + TILES*(2*N+2));
    wait_idle();

    // All -1, lower half active, consumer stalls 10 cycles.
    set_uniform(-1, 32'h0000FFFF);
    bus.out_ready = 1'b0;
    queue_eval(0);
    pulse_start();
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 2000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid,      1);
      check("hold_acc",   int'(bus.out_acc),  -64);
      check("hold_act",   bus.out_act,        0);
    end
    bus.out_ready = 1'b1;
    wait_idle();

    // Random ternary weights with 50% stream gaps.
    gaps = 1'b1;
    for (int r = 0; r < 3; r++) begin
      set_random();
      queue_eval(int'($urandom_range(80, 0)) - 40);
      pulse_start();
      wait_idle();
      check("wt_drained", wt_q.size(), 0);
      check("x_drained",  x_q.size(),  0);
    end
    gaps = 1'b0;

    // Abort during CAPTURE of tile index 2, then a fresh evaluation.
    set_uniform(1, '1);
    for (int t = 0; t < TILES; t++) cur_x[t] = N'(32'h0F0F_0000 + t);
    queue_eval(0);
    pulse_start();
    fires = 0;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
      if (bus.x_valid && bus.x_ready) fires++;
    end while (fires < 3 && n < 2000);
    @(negedge clk); bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    #1;
    check("abort_busy",      bus.busy,      0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_acc",       bus.out_acc,   0);
    check("abort_x_out",     bus.x_out,     cur_x[2]);
    flush_streams();
    @(negedge clk);

    set_random();
    queue_eval(3);
    pulse_start();
    repeat (20) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check("start_while_busy", bus.wt_ready, 1);
    wait_idle();
    repeat (5) @(negedge clk);
    check("sb_leftover", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
